// File: rtl/mem_req_ctrl_if.sv
// Request/response handshake bundle between a requester and mem_req_ctrl.
// slave = controller side, master = requester side.
interface mem_req_ctrl_if #(
    parameter int AW = 2,
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Single-outstanding request controller in front of a 4x8 synchronous memory:
// registered one-cycle strobes, one-cycle read latency, wrapping debug counters.
module mem_req_ctrl #(
    parameter int AW = 2,
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_req_ctrl_if.slave bus,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_w_data,
    input  logic [DW-1:0] mem_r_data,
    output logic [CW-1:0] wr_count,
    output logic [CW-1:0] rd_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_req_fire;

    logic          r_mem_wr_en;
    logic          r_mem_rd_en;
    logic [AW-1:0] r_mem_address;
    logic [DW-1:0] r_mem_w_data;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_rdata;
    logic [CW-1:0] r_wr_count;
    logic [CW-1:0] r_rd_count;

    assign w_req_fire = (r_state == IDLE) && bus.req_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_state_nxt = bus.req_write ? WRITE : READ;
            WRITE:   w_state_nxt = IDLE;
            READ:    w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Strobes are registered from the next state so they line up exactly
    // with WRITE/READ; the request fields are captured straight into the pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_wr_en   <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_address <= '0;
            r_mem_w_data  <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_wr_count    <= '0;
            r_rd_count    <= '0;
        end else begin
            r_mem_wr_en <= (w_state_nxt == WRITE);
            r_mem_rd_en <= (w_state_nxt == READ);
            if (w_req_fire) begin
                r_mem_address <= bus.req_addr;
                r_mem_w_data  <= bus.req_write ? bus.req_wdata : '0;
            end else begin
                r_mem_address <= '0;
                r_mem_w_data  <= '0;
            end
            if (r_state == CAPTURE) r_rsp_rdata <= mem_r_data;
            r_rsp_valid <= (w_state_nxt == RESP);
            if (r_state == WRITE)                  r_wr_count <= r_wr_count + CW'(1);
            if (r_state == RESP && bus.rsp_ready)  r_rd_count <= r_rd_count + CW'(1);
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign mem_wr_en     = r_mem_wr_en;
    assign mem_rd_en     = r_mem_rd_en;
    assign mem_address   = r_mem_address;
    assign mem_w_data    = r_mem_w_data;
    assign wr_count      = r_wr_count;
    assign rd_count      = r_rd_count;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural 4x8 memory attached.
module tb_mem_req_ctrl;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_w_data;
    logic [DW-1:0] mem_r_data;
    logic [CW-1:0] wr_count, rd_count;
    logic [DW-1:0] mem [4];

    int nvec = 0;
    int nerr = 0;

    mem_req_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    mem_req_ctrl #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_en   (mem_rd_en),
        .mem_address (mem_address),
        .mem_w_data  (mem_w_data),
        .mem_r_data  (mem_r_data),
        .wr_count    (wr_count),
        .rd_count    (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_address] <= mem_w_data;
        if (mem_rd_en) mem_r_data <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_timeout", 32'(bus.req_ready === 1'b1), 32'd1);
    endtask

    // Entered and left at posedge+1.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_ready();
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_wdata = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("wr_strobe", 32'(mem_wr_en), 32'd1);
        chk("wr_no_rd", 32'(mem_rd_en), 32'd0);
        chk("wr_addr", 32'(mem_address), 32'(a));
        chk("wr_data", 32'(mem_w_data), 32'(d));
        chk("wr_busy", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("wr_strobe_off", 32'(mem_wr_en), 32'd0);
        chk("wr_ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        wait_ready();
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_wdata = 8'hEE;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rd_strobe", 32'(mem_rd_en), 32'd1);
        chk("rd_no_wr", 32'(mem_wr_en), 32'd0);
        chk("rd_addr", 32'(mem_address), 32'(a));
        chk("rd_rsp_early", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("cap_strobe_off", 32'(mem_rd_en), 32'd0);
        chk("cap_rsp_early", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp));
        chk("rsp_busy", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("rsp_done", 32'(bus.rsp_valid), 32'd0);
        chk("rd_ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Reset applied from time 0; outputs must be cleared before any edge.
        #3;
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_wdata", 32'(mem_w_data), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        #20 reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Write then read back.
        do_write(2'd2, 8'hA5);
        do_read(2'd2, 8'hA5);
        chk("wr_count_1", 32'(wr_count), 32'd1);
        chk("rd_count_1", 32'(rd_count), 32'd1);

        // Every address, read back out of order.
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'h22);
        do_write(2'd2, 8'h33);
        do_write(2'd3, 8'h44);
        do_read(2'd3, 8'h44);
        do_read(2'd0, 8'h11);
        do_read(2'd2, 8'h33);
        do_read(2'd1, 8'h22);
        chk("wr_count_5", 32'(wr_count), 32'd5);
        chk("rd_count_5", 32'(rd_count), 32'd5);

        // Response backpressure with a write waiting behind it.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 2'd1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 2'd0; bus.req_wdata = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", 32'(bus.rsp_rdata), 32'h22);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_no_write", 32'(mem_wr_en), 32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rsp_drop", 32'(bus.rsp_valid), 32'd0);
        chk("bp_rd_count", 32'(rd_count), 32'd6);
        chk("bp_ready_back", 32'(bus.req_ready), 32'd1);
        chk("bp_wr_not_yet", 32'(mem_wr_en), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("bp_wr_issue", 32'(mem_wr_en), 32'd1);
        chk("bp_wr_addr", 32'(mem_address), 32'd0);
        chk("bp_wr_data", 32'(mem_w_data), 32'h5A);
        @(posedge clk); #1;
        chk("bp_wr_count", 32'(wr_count), 32'd6);

        // Reset while the read sits in CAPTURE.
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 2'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("mid_rst_rd_count", 32'(rd_count), 32'd0);
        chk("mid_rst_wr_count", 32'(wr_count), 32'd0);
        @(posedge clk); #3;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("post_rst_rd_count", 32'(rd_count), 32'd0);
        end
        do_read(2'd3, 8'h44);
        chk("post_rst_rd_count_1", 32'(rd_count), 32'd1);

        // 257 writes: counter wraps 255 -> 0 -> 1.
        for (int k = 0; k < 257; k++) do_write(2'(k), 8'(k));
        chk("wrap_wr_count", 32'(wr_count), 32'd1);
        chk("wrap_rd_count", 32'(rd_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
